// File: rtl/modexp_ctrl.sv
// modexp_ctrl: sequences one modmult instance to compute base^exponent mod N (left-to-right square-and-multiply).
// Optional build macro MODEXP_CONST_TIME_EN selects a fixed 2*ELEN-op schedule independent of the exponent value.
module modexp_ctrl #(
   parameter int NLEN = 1024,
   parameter int TAG  = 2,
   parameter int ELEN = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [NLEN:0]     base,
   input  logic [ELEN-1:0]   exponent,
   input  logic [NLEN:0]     N,
   output logic              busy,
   output logic              done,
   output logic [NLEN:0]     result,
   output logic              mm_reset,
   output logic              mm_in_ready,
   output logic [NLEN+TAG:0] mm_in1,
   output logic [NLEN+TAG:0] mm_in2,
   output logic [NLEN:0]     mm_N,
   input  logic [NLEN+TAG:0] mm_out,
   input  logic              mm_out_ready
);
   localparam int W  = NLEN + TAG + 1;
   localparam int IW = (ELEN > 1) ? $clog2(ELEN) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(ELEN - 1);
   localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
   localparam logic [NLEN:0] ONE     = {{NLEN{1'b0}}, 1'b1};
   localparam logic [NLEN:0] ZERO    = {(NLEN+1){1'b0}};

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_NEXT, S_RST, S_ISSUE, S_WAIT, S_CAP, S_FINISH
   } state_t;
   typedef enum logic {OP_SQ, OP_MUL} op_t;

   state_t          state_q, state_d;
   op_t             op_q, op_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [NLEN:0]   acc_q, acc_d;
   logic [NLEN:0]   base_q, base_d;
   logic [NLEN:0]   n_q, n_d;
   logic [NLEN:0]   result_q, result_d;
   logic [ELEN-1:0] exp_q, exp_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            in_rdy_q, in_rdy_d;
   logic            exp_bit_s;
   logic [NLEN:0]   prod_s;

   // Single-step range correction of a signed product p into [0, N).
   function automatic logic [NLEN:0] correct(input logic [W-1:0] p, input logic [NLEN:0] n);
      logic signed [W-1:0] ps;
      logic signed [W-1:0] ns;
      logic signed [W-1:0] rs;
      ps = p;
      ns = {{TAG{n[NLEN]}}, n};
      if (ps[W-1]) begin
         rs = ps + ns;
      end else if (ps >= ns) begin
         rs = ps - ns;
      end else begin
         rs = ps;
      end
      return rs[NLEN:0];
   endfunction

   assign exp_bit_s = exp_q[idx_q];
   assign prod_s    = correct(mm_out, n_q);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      base_d   = base_q;
      n_d      = n_q;
      exp_d    = exp_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      in_rdy_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d = base;
               exp_d  = exponent;
               n_d    = N;
               idx_d  = IDX_TOP;
               busy_d = 1'b1;
`ifdef MODEXP_CONST_TIME_EN
               acc_d   = ONE;
               op_d    = OP_SQ;
               state_d = S_RST;
`else
               state_d = S_SCAN;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (exp_bit_s) begin
               acc_d   = base_q;
               state_d = S_NEXT;
            end else if (idx_q != {IW{1'b0}}) begin
               idx_d = idx_q - IDX_ONE;
            end else begin
               acc_d   = ONE;
               state_d = S_FINISH;
            end
         end
         S_NEXT: begin
            if (idx_q == {IW{1'b0}}) begin
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q - IDX_ONE;
               op_d    = OP_SQ;
               state_d = S_RST;
            end
         end
         S_RST: begin
            in_rdy_d = 1'b1;
            state_d  = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mm_out_ready) begin
               state_d = S_CAP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_CAP: begin
            case (op_q)
               OP_SQ: begin
                  acc_d = prod_s;
`ifdef MODEXP_CONST_TIME_EN
                  op_d    = OP_MUL;
                  state_d = S_RST;
`else
                  if (exp_bit_s) begin
                     op_d    = OP_MUL;
                     state_d = S_RST;
                  end else begin
                     state_d = S_NEXT;
                  end
`endif
               end
               OP_MUL: begin
`ifdef MODEXP_CONST_TIME_EN
                  // Dummy multiply keeps timing flat; product kept only for set bits.
                  if (exp_bit_s) begin
                     acc_d = prod_s;
                  end else begin
                     acc_d = acc_q;
                  end
`else
                  acc_d = prod_s;
`endif
                  state_d = S_NEXT;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_FINISH: begin
            result_d = (acc_q == n_q) ? ZERO : acc_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_SQ;
         idx_q    <= {IW{1'b0}};
         acc_q    <= ZERO;
         base_q   <= ZERO;
         n_q      <= ZERO;
         exp_q    <= {ELEN{1'b0}};
         result_q <= ZERO;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         in_rdy_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         base_q   <= base_d;
         n_q      <= n_d;
         exp_q    <= exp_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         in_rdy_q <= in_rdy_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign mm_in_ready = in_rdy_q;
   assign mm_reset    = reset | (state_q == S_RST);
   assign mm_N        = n_q;
   assign mm_in1      = {{TAG{acc_q[NLEN]}}, acc_q};
   assign mm_in2      = (op_q == OP_MUL) ? {{TAG{base_q[NLEN]}}, base_q} : {{TAG{acc_q[NLEN]}}, acc_q};

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: scoreboard bench for modexp_ctrl with a behavioural modmult returning out-of-range products.
// Expected results and op counts are hand-computed; build with MODEXP_CONST_TIME_EN for the constant-time flow.
module tb_modexp_ctrl;
   localparam int NLEN = 8;
   localparam int TAG  = 2;
   localparam int ELEN = 8;
   localparam int W    = NLEN + TAG + 1;
   localparam int LAT  = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [NLEN:0]     base;
   logic [ELEN-1:0]   exponent;
   logic [NLEN:0]     N;
   logic              busy;
   logic              done;
   logic [NLEN:0]     result;
   logic              mm_reset;
   logic              mm_in_ready;
   logic [W-1:0]      mm_in1;
   logic [W-1:0]      mm_in2;
   logic [NLEN:0]     mm_N;
   logic [W-1:0]      mm_out = '0;
   logic              mm_out_ready = 1'b0;

   typedef struct {
      int res;
      int ops;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cyc = 0;
   int op_count = 0;
   int op_mark  = 0;
   int last_lat = 0;
   int ma = 0, mb = 0, mn = 1, mcnt = 0, mk = 0;
   logic mbusy = 1'b0;

   modexp_ctrl #(.NLEN(NLEN), .TAG(TAG), .ELEN(ELEN)) dut (
      .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent), .N(N),
      .busy(busy), .done(done), .result(result), .mm_reset(mm_reset), .mm_in_ready(mm_in_ready),
      .mm_in1(mm_in1), .mm_in2(mm_in2), .mm_N(mm_N), .mm_out(mm_out), .mm_out_ready(mm_out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Product mod n, deliberately offset into [-n, 2n) so the DUT correction is exercised.
   function automatic int model_out(input int a, input int b, input int n, input int k);
      int r;
      r = (a * b) % n;
      case (k)
         0: return r;
         1: return r - n;
         default: return r + n;
      endcase
   endfunction

   always @(posedge clk) begin
      if (mm_reset) begin
         mm_out_ready <= 1'b0;
         mbusy        <= 1'b0;
         mcnt         <= 0;
      end else if (mm_in_ready) begin
         ma       <= int'($signed(mm_in1));
         mb       <= int'($signed(mm_in2));
         mn       <= int'(mm_N);
         mcnt     <= LAT;
         mbusy    <= 1'b1;
         op_count <= op_count + 1;
      end else if (mbusy) begin
         if (mcnt == 1) begin
            mm_out       <= W'(model_out(ma, mb, mn, mk));
            mm_out_ready <= 1'b1;
            mbusy        <= 1'b0;
            mk           <= (mk + 1) % 3;
         end
         mcnt <= mcnt - 1;
      end
   end

   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending request");
         end else begin
            exp_t x;
            x = sb_q.pop_front();
            chk("result", int'(result), x.res);
            chk("op_count", op_count - op_mark, x.ops);
            last_lat = cyc - start_cyc;
         end
      end
   end

   task automatic run(input int b, input int e, input int n, input int res, input int ops_vt, input bit poke);
      exp_t x;
      int t;
      x.res = res;
      x.ops = ops_vt;
`ifdef MODEXP_CONST_TIME_EN
      x.ops = 2 * ELEN;
`endif
      @(negedge clk);
      base      = 9'(b);
      exponent  = 8'(e);
      N         = 9'(n);
      start     = 1'b1;
      op_mark   = op_count;
      start_cyc = cyc;
      sb_q.push_back(x);
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (sb_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
         if (poke && t == 4) begin
            base     = 9'd1;
            exponent = 8'd3;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (t >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got no done after %0d cycles expected done", t);
         sb_q.delete();
      end
      repeat (3) @(negedge clk);
      chk("result_hold", int'(result), res);
      chk("busy_idle", int'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int lat_a;
      reset = 1'b1; start = 1'b0; base = '0; exponent = '0; N = 9'd7;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_in_ready", int'(mm_in_ready), 0);
      chk("rst_mm_reset", int'(mm_reset), 1);
      reset = 1'b0;

      run(3, 5, 7, 5, 3, 1'b1);
      lat_a = last_lat;
      run(2, 12, 13, 1, 4, 1'b0);
      run(5, 0, 7, 1, 0, 1'b0);
`ifdef MODEXP_CONST_TIME_EN
      chk("const_time_latency", last_lat, lat_a);
`else
      chk("exp0_latency_le", int'(last_lat <= ELEN + 2), 1);
`endif
      run(0, 5, 7, 0, 3, 1'b0);
      run(4, 1, 7, 4, 0, 1'b0);
      run(10, 255, 11, 10, 14, 1'b1);
      run(7, 128, 11, 9, 7, 1'b0);
      run(2, 2, 3, 1, 1, 1'b0);
      run(200, 3, 251, 128, 2, 1'b0);

      // Abort a run while the second op is outstanding; no scoreboard entry is expected.
      @(negedge clk);
      base = 9'd2; exponent = 8'd12; N = 9'd13; start = 1'b1;
      op_mark = op_count;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while ((op_count - op_mark) < 2 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("abort_reached_op2", op_count - op_mark, 2);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_result", int'(result), 0);
      chk("abort_mm_reset", int'(mm_reset), 1);
      reset = 1'b0;
      run(2, 12, 13, 1, 4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
